led_dim_ctrl: RTL
=================

LED_DIM_CTRL -- requirements
Module: led_dim_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000; clk cycles per ramp tick.
REQ-002 SHALL have parameter STEP, default 1; duty change per ramp tick.
REQ-003 SHALL have parameter DUTY_MIN, default 4; lowest auto-mode duty.
REQ-004 SHALL have parameter DUTY_MAX, default 62; highest duty, matching the 63-count PWM period.
REQ-005 SHALL have parameter LUX_SHIFT, default 4; right shift applied to lux for mapping.
REQ-006 SHALL have parameter TIMEOUT_TICKS, default 2000; ticks without a sample before fallback.
REQ-007 SHALL have parameter FALLBACK_DUTY, default 32; duty target on sensor loss.
REQ-008 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-009 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-010 SHALL have port lux_valid  input  1  sensor sample valid.
REQ-011 SHALL have port lux_data  input  16  BH1750 lux count.
REQ-012 SHALL have port lux_ready  output  1  sample accepted when lux_valid and lux_ready are both 1.
REQ-013 SHALL have port man_en  input  1  manual override enable.
REQ-014 SHALL have port man_duty  input  8  manual duty request.
REQ-015 SHALL have port pwm_duty  output  8  duty to the PWM LED driver.
REQ-016 SHALL have port at_target  output  1  pwm_duty equals current target.
REQ-017 SHALL have port sensor_fault  output  1  timeout fallback active.

Function
REQ-018 SHALL generate a 1-cycle tick when the free-running divider reaches TICK_DIV-1, then wrap the divider to 0.
REQ-019 SHALL implement FSM states IDLE, MAP, RAMP.
REQ-020 SHALL drive lux_ready=1 in IDLE and RAMP, and 0 in MAP.
REQ-021 SHALL, on an accepted sample, register lux_data, enter MAP, clear the timeout count and clear sensor_fault in the same cycle.
REQ-022 SHALL, in MAP for exactly 1 cycle, compute auto_target = clamp(lux>>LUX_SHIFT, DUTY_MIN, DUTY_MAX), with the comparison at full 16-bit width (no truncation before the clamp), then enter RAMP.
REQ-023 SHALL select the effective target by priority: man_en gives min(man_duty, DUTY_MAX), with no DUTY_MIN floor; else sensor_fault gives FALLBACK_DUTY; else auto_target.
REQ-024 SHALL re-evaluate the effective target every cycle, so that a man_en or man_duty change, or fault entry, while in IDLE moves the FSM to RAMP on the next cycle if pwm_duty differs from the target.
REQ-025 SHALL, in RAMP on each tick, move pwm_duty toward the target by STEP without overshoot (saturate at the target).
REQ-026 SHALL make no change to pwm_duty on a non-tick cycle.
REQ-027 SHALL return to IDLE from RAMP in the cycle after pwm_duty equals the target.
REQ-028 SHALL, on a sample accepted during RAMP, enter MAP, keep pwm_duty unchanged, and resume ramping from the current value.
REQ-029 SHALL still accept samples while man_en=1 and update auto_target, but pwm_duty SHALL follow the manual target.
REQ-030 SHALL increment the timeout count on each tick, saturating at TIMEOUT_TICKS.
REQ-031 SHALL set sensor_fault when the timeout count reaches TIMEOUT_TICKS.
REQ-032 SHALL give an accepted sample priority over timeout expiry when both fall in the same cycle: count cleared, no fault.
REQ-033 SHALL drive at_target = (pwm_duty == effective target), combinationally from registers.

Reset
REQ-034 SHALL, with rst=1 at a clock edge, set state=IDLE, pwm_duty=0, auto_target=DUTY_MIN, divider=0, timeout count=0, sensor_fault=0.
REQ-035 SHALL hold lux_ready=0 while rst=1.
REQ-036 SHALL, on reset mid-ramp, abandon the ramp immediately; the next ramp starts from 0.
REQ-037 SHALL, after reset release with man_en=0 and no sample, ramp pwm_duty to DUTY_MIN.

Verification (TICK_DIV=4, TIMEOUT_TICKS=8)
REQ-038 SHALL cover: reset release, idle -> pwm_duty ramps 0,1,2,3,4 on successive ticks (one every 4 clk), then at_target=1 and state IDLE.
REQ-039 SHALL cover: sample lux_data=0x0200 accepted -> lux_ready=0 one cycle, target=32, pwm_duty steps +1 per tick up to 32.
REQ-040 SHALL cover: lux_data=0xFFFF -> target 62; lux_data=0x0010 -> target clamped to 4.
REQ-041 SHALL cover: mid-ramp at pwm_duty=20 toward 32, new sample 0x0080 (target 8) -> no jump, pwm_duty steps down 20,19,...,8.
REQ-042 SHALL cover: man_en=1, man_duty=200 -> target 62 despite sensor target 8; man_en=0 -> ramps back to 8.
REQ-043 SHALL cover: no samples for 8 ticks -> sensor_fault=1, ramp to 32; next sample at the expiry cycle -> sensor_fault stays 0.

Source files
------------

// File: rtl/led_dim_ctrl.sv
// LED dimming controller.
// Maps ambient-light samples to a PWM duty target and ramps the driven duty
// toward that target one STEP per divider tick. A manual override can take
// over the target at any time. If no sample arrives for TIMEOUT_TICKS ticks,
// the controller falls back to a fixed duty and flags sensor_fault.
module led_dim_ctrl #(
    parameter int TICK_DIV      = 50000,
    parameter int STEP          = 1,
    parameter int DUTY_MIN      = 4,
    parameter int DUTY_MAX      = 62,
    parameter int LUX_SHIFT     = 4,
    parameter int TIMEOUT_TICKS = 2000,
    parameter int FALLBACK_DUTY = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lux_valid,
    input  logic [15:0] lux_data,
    output logic        lux_ready,
    input  logic        man_en,
    input  logic [7:0]  man_duty,
    output logic [7:0]  pwm_duty,
    output logic        at_target,
    output logic        sensor_fault
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAP  = 2'd1,
        RAMP = 2'd2
    } state_e;

    state_e            state_r;
    state_e            state_nxt_s;
    logic [DIV_W-1:0]  div_r;
    logic              tick_s;
    logic [TO_W-1:0]   to_cnt_r;
    logic              fault_r;
    logic [15:0]       lux_r;
    logic [7:0]        auto_target_r;
    logic [7:0]        auto_nxt_s;
    logic [7:0]        pwm_r;
    logic [7:0]        pwm_nxt_s;
    logic [7:0]        man_clip_s;
    logic [7:0]        target_s;
    logic              ready_s;
    logic              accept_s;

    // Lux-to-duty mapping. The clamp compares the full 16-bit shifted value
    // so that large lux readings cannot wrap into a small duty.
    function automatic logic [7:0] map_lux(input logic [15:0] lux);
        logic [15:0] sh;
        sh = lux >> LUX_SHIFT;
        if (sh < 16'(DUTY_MIN)) begin
            return 8'(DUTY_MIN);
        end else if (sh > 16'(DUTY_MAX)) begin
            return 8'(DUTY_MAX);
        end else begin
            return sh[7:0];
        end
    endfunction

    // One ramp step from cur toward tgt, saturating at tgt.
    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        logic [8:0] gap;
        if (cur < tgt) begin
            gap = {1'b0, tgt} - {1'b0, cur};
            if (gap > 9'(STEP)) begin
                return cur + 8'(STEP);
            end else begin
                return tgt;
            end
        end else if (cur > tgt) begin
            gap = {1'b0, cur} - {1'b0, tgt};
            if (gap > 9'(STEP)) begin
                return cur - 8'(STEP);
            end else begin
                return tgt;
            end
        end else begin
            return cur;
        end
    endfunction

    assign tick_s       = (div_r == DIV_W'(TICK_DIV - 1));
    assign ready_s      = (state_r != MAP) && !rst;
    assign accept_s     = lux_valid && ready_s;
    assign man_clip_s   = (man_duty > 8'(DUTY_MAX)) ? 8'(DUTY_MAX) : man_duty;
    assign lux_ready    = ready_s;
    assign pwm_duty     = pwm_r;
    assign sensor_fault = fault_r;
    assign at_target    = (pwm_r == target_s);

    // Effective target: manual override, then sensor-loss fallback, then mapped lux.
    always_comb begin
        target_s = auto_target_r;
        if (man_en) begin
            target_s = man_clip_s;
        end else if (fault_r) begin
            target_s = 8'(FALLBACK_DUTY);
        end else begin
            target_s = auto_target_r;
        end
    end

    // Free-running tick divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r <= '0;
        end else if (tick_s) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // Sensor-loss timeout; an accepted sample always wins over expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_r <= '0;
            fault_r  <= 1'b0;
        end else if (accept_s) begin
            to_cnt_r <= '0;
            fault_r  <= 1'b0;
        end else if (tick_s) begin
            if (to_cnt_r < TO_W'(TIMEOUT_TICKS)) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end else begin
                to_cnt_r <= to_cnt_r;
            end
            if (to_cnt_r >= TO_W'(TIMEOUT_TICKS - 1)) begin
                fault_r <= 1'b1;
            end else begin
                fault_r <= fault_r;
            end
        end else begin
            to_cnt_r <= to_cnt_r;
            fault_r  <= fault_r;
        end
    end

    // FSM state, sample capture, mapped target and driven duty registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            lux_r         <= 16'd0;
            auto_target_r <= 8'(DUTY_MIN);
            pwm_r         <= 8'd0;
        end else begin
            state_r       <= state_nxt_s;
            lux_r         <= accept_s ? lux_data : lux_r;
            auto_target_r <= auto_nxt_s;
            pwm_r         <= pwm_nxt_s;
        end
    end

    // Next-state and ramp logic; a new sample pre-empts ramping without touching the duty.
    always_comb begin
        state_nxt_s = state_r;
        auto_nxt_s  = auto_target_r;
        pwm_nxt_s   = pwm_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = MAP;
                end else if (pwm_r != target_s) begin
                    state_nxt_s = RAMP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MAP: begin
                auto_nxt_s  = map_lux(lux_r);
                state_nxt_s = RAMP;
            end
            RAMP: begin
                if (accept_s) begin
                    state_nxt_s = MAP;
                end else if (pwm_r == target_s) begin
                    state_nxt_s = IDLE;
                end else if (tick_s) begin
                    pwm_nxt_s   = step_toward(pwm_r, target_s);
                    state_nxt_s = RAMP;
                end else begin
                    state_nxt_s = RAMP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

endmodule
